// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: miss detection, scoring and IDLE/SERVE/RUNNING/GAME_OVER phasing.
// All outputs registered; state, scores and enables change on the same clock edge.
module pong_game_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 5,
  parameter int c_P1_PADDLE_X   = 0,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_DELAY   = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_P1_Paddle_Y,
  input  logic [5:0] i_P2_Paddle_Y,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  localparam int CW = $clog2(c_SERVE_DELAY + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(c_SERVE_DELAY - 1);
  localparam logic [3:0]    LIMIT      = 4'(c_SCORE_LIMIT);
  localparam logic [5:0]    P1_COL     = 6'(c_P1_PADDLE_X);
  localparam logic [5:0]    P2_COL     = 6'(c_GAME_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RUNNING   = 3'd2,
    GAME_OVER = 3'd3
  } state_t;

  state_t        state;
  logic          start_q;
  logic [CW-1:0] serve_cnt;

  logic       start_evt;
  logic [6:0] ball_y7, p1_top, p2_top, p1_bot, p2_bot;
  logic       p1_miss, p2_miss;
  logic [3:0] p1_inc, p2_inc;

  assign start_evt = i_Start & ~start_q;

  // Paddle spans are evaluated at 7 bits so top+height never wraps.
  assign ball_y7 = {1'b0, i_Ball_Y};
  assign p1_top  = {1'b0, i_P1_Paddle_Y};
  assign p2_top  = {1'b0, i_P2_Paddle_Y};
  assign p1_bot  = p1_top + 7'(c_PADDLE_HEIGHT);
  assign p2_bot  = p2_top + 7'(c_PADDLE_HEIGHT);
  assign p1_miss = (i_Ball_X == P1_COL) && ((ball_y7 < p1_top) || (ball_y7 > p1_bot));
  assign p2_miss = (i_Ball_X == P2_COL) && ((ball_y7 < p2_top) || (ball_y7 > p2_bot));

  assign p1_inc  = (o_P1_Score < LIMIT) ? o_P1_Score + 4'd1 : o_P1_Score;
  assign p2_inc  = (o_P2_Score < LIMIT) ? o_P2_Score + 4'd1 : o_P2_Score;
  assign o_State = state;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      serve_cnt     <= '0;
      o_P1_Score    <= 4'd0;
      o_P2_Score    <= 4'd0;
      o_Winner      <= 2'b00;
      o_Game_Active <= 1'b0;
      o_Ball_Reset  <= 1'b1;
    end else begin
      start_q <= i_Start;
      case (state)
        IDLE, GAME_OVER: begin
          o_Game_Active <= 1'b0;
          o_Ball_Reset  <= 1'b1;
          if (start_evt) begin
            state      <= SERVE;
            serve_cnt  <= '0;
            o_P1_Score <= 4'd0;
            o_P2_Score <= 4'd0;
            o_Winner   <= 2'b00;
          end
        end
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            state         <= RUNNING;
            serve_cnt     <= '0;
            o_Game_Active <= 1'b1;
            o_Ball_Reset  <= 1'b0;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        RUNNING: begin
          // P1 miss takes priority when both columns coincide.
          if (p1_miss || p2_miss) begin
            o_Game_Active <= 1'b0;
            o_Ball_Reset  <= 1'b1;
            serve_cnt     <= '0;
            if (p1_miss) begin
              o_P2_Score <= p2_inc;
              if (p2_inc == LIMIT) begin
                state    <= GAME_OVER;
                o_Winner <= 2'b10;
              end else begin
                state <= SERVE;
              end
            end else begin
              o_P1_Score <= p1_inc;
              if (p1_inc == LIMIT) begin
                state    <= GAME_OVER;
                o_Winner <= 2'b01;
              end else begin
                state <= SERVE;
              end
            end
          end
        end
        default: begin
          state         <= IDLE;
          serve_cnt     <= '0;
          o_Game_Active <= 1'b0;
          o_Ball_Reset  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and directed bench for pong_game_ctrl against a phase-level game model.
module tb_pong_game_ctrl;

  localparam int DELAY = 4;
  localparam int LIMIT = 3;
  localparam int WIDTH = 40;
  localparam int PH    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] ball_x = 6'd20, ball_y = 6'd15, p1_y = 6'd10, p2_y = 6'd10;
  logic       game_active, ball_reset;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Game model: phase 0 idle, 1 serve, 2 play, 3 over.
  int m_phase = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_left = 0;
  bit m_prev = 1'b0;

  pong_game_ctrl #(
    .c_GAME_WIDTH(WIDTH), .c_GAME_HEIGHT(30), .c_PADDLE_HEIGHT(PH),
    .c_P1_PADDLE_X(0), .c_SCORE_LIMIT(LIMIT), .c_SERVE_DELAY(DELAY)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .i_Ball_X(ball_x), .i_Ball_Y(ball_y),
    .i_P1_Paddle_Y(p1_y), .i_P2_Paddle_Y(p2_y),
    .o_Game_Active(game_active), .o_Ball_Reset(ball_reset),
    .o_P1_Score(p1_score), .o_P2_Score(p2_score),
    .o_Winner(winner), .o_State(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit missed(input int col, input int pad);
    return (int'(ball_x) == col) && !(int'(ball_y) inside {[pad:pad+PH]});
  endfunction

  task automatic new_game();
    m_p1 = 0; m_p2 = 0; m_win = 0; m_phase = 1; m_left = DELAY;
  endtask

  task automatic score(input int who);
    if (who == 1) m_p1++; else m_p2++;
    if (m_p1 == LIMIT || m_p2 == LIMIT) begin
      m_phase = 3; m_win = who;
    end else begin
      m_phase = 1; m_left = DELAY;
    end
  endtask

  task automatic model_step();
    bit ev;
    ev = start && !m_prev;
    if (rst) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_prev = 1'b0;
    end else begin
      m_prev = start;
      if (m_phase == 0 || m_phase == 3) begin
        if (ev) new_game();
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else begin
        if (missed(0, int'(p1_y))) score(2);
        else if (missed(WIDTH - 1, int'(p2_y))) score(1);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("state",  int'(state),       m_phase);
    chk("active", int'(game_active), int'(m_phase == 2));
    chk("ballrst",int'(ball_reset),  int'(m_phase != 2));
    chk("p1",     int'(p1_score),    m_p1);
    chk("p2",     int'(p2_score),    m_p2);
    chk("winner", int'(winner),      m_win);
  endtask

  task automatic wait_play();
    ball_x = 6'd20;
    for (int i = 0; i < 10 && m_phase != 2; i++) tick();
    chk("reach_play", int'(state), 2);
  endtask

  task automatic miss_at(input int col, input int pad_y, input int y);
    ball_x = 6'(col); ball_y = 6'(y);
    if (col == 0) p1_y = 6'(pad_y); else p2_y = 6'(pad_y);
    tick();
    ball_x = 6'd20;
  endtask

  initial begin
    // 1. reset then start; SERVE lasts exactly DELAY clocks
    rst = 1'b1; tick(); tick();
    chk("rst_state", int'(state), 0);
    rst = 1'b0; start = 1'b1; tick();
    chk("serve_entry", int'(state), 1);
    chk("serve_ballrst", int'(ball_reset), 1);
    start = 1'b0;
    for (int i = 0; i < DELAY - 1; i++) begin
      tick();
      chk("serve_inactive", int'(game_active), 0);
    end
    tick();
    chk("active_rise", int'(game_active), 1);

    // 2. boundary rows are hits
    p1_y = 6'd10; ball_x = 6'd0; ball_y = 6'd10; tick();
    ball_y = 6'd15; tick();
    chk("boundary_state", int'(state), 2);
    chk("boundary_p2", int'(p2_score), 0);

    // 3. P1 miss
    ball_y = 6'd16; tick();
    chk("p1miss_p2", int'(p2_score), 1);
    chk("p1miss_state", int'(state), 1);
    wait_play();

    // 4. win by three P2-column misses
    for (int k = 0; k < 3; k++) begin
      miss_at(WIDTH - 1, 0, 20);
      if (k < 2) wait_play();
    end
    chk("win_p1", int'(p1_score), 3);
    chk("win_winner", int'(winner), 1);
    chk("win_state", int'(state), 3);
    miss_at(WIDTH - 1, 0, 20);
    miss_at(0, 10, 40);
    chk("over_hold_p1", int'(p1_score), 3);

    // 5. restart from GAME_OVER with start held high
    start = 1'b1; tick();
    chk("restart_state", int'(state), 1);
    chk("restart_p1", int'(p1_score), 0);
    for (int i = 0; i < 8; i++) tick();
    chk("held_start_play", int'(state), 2);
    start = 1'b0;

    // 6. reset mid-serve with scores 2/1
    miss_at(WIDTH - 1, 0, 20); wait_play();
    miss_at(WIDTH - 1, 0, 20); wait_play();
    miss_at(0, 10, 2);
    chk("pre_rst_p1", int'(p1_score), 2);
    chk("pre_rst_p2", int'(p2_score), 1);
    rst = 1'b1; tick();
    chk("midrst_state", int'(state), 0);
    chk("midrst_p1", int'(p1_score), 0);
    rst = 1'b0;

    // randomized play with occasional resets and start toggles
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0: ball_x = 6'd0;
        1: ball_x = 6'(WIDTH - 1);
        default: ball_x = 6'($urandom_range(0, 63));
      endcase
      ball_y = 6'($urandom_range(0, 63));
      p1_y   = 6'($urandom_range(0, 63));
      p2_y   = 6'($urandom_range(0, 63));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
